// File: rtl/mux_scan_pkg.sv
// Shared definitions for the scanning channel multiplexer: FSM state
// encoding, mode constants, last-active-mode encoding and the state decoder.
package mux_scan_pkg;

    // Operating state, re-decoded from en/mode on every clock edge.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    // Values of the mode input.
    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Remembers which active mode ran last, so a pause can resume a scan.
    typedef enum logic {
        LAST_MANUAL = 1'b0,
        LAST_SCAN   = 1'b1
    } last_active_t;

    // Map the control inputs onto the state the block operates in this edge.
    function automatic state_t decode_state(input logic en, input logic mode);
        state_t st;
        st = ST_IDLE;
        if (en == 1'b0) begin
            st = ST_IDLE;
        end else begin
            case (mode)
                MODE_MANUAL: st = ST_MANUAL;
                MODE_SCAN:   st = ST_SCAN;
                default:     st = ST_IDLE;
            endcase
        end
        return st;
    endfunction

endpackage

// File: rtl/mux_scan_sel_scan_counter.sv
// Scan position tracker: a dwell counter (0..DWELL-1) nested inside a channel
// counter (0..CHANNELS-1). The registers hold the position currently on the
// output; chan_next/wrap_next describe the position about to be shown, so the
// top level can register the data for that channel on the same edge.
module scan_counter #(
    parameter int CHANNELS = 4,
    parameter int DWELL    = 8,
    parameter int SEL_W    = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clear,      // restart at channel 0, dwell 0
    input  logic             hold,       // freeze both counters
    output logic [SEL_W-1:0] chan_next,  // channel shown after this edge
    output logic             wrap_next   // this edge wraps last channel -> 0
);
    import mux_scan_pkg::*;

    localparam int DWELL_W = $clog2(DWELL) + 1;
    localparam logic [DWELL_W-1:0] LAST_DWELL = DWELL_W'(DWELL - 1);
    localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);
    localparam logic [SEL_W-1:0]   LAST_CHAN  = SEL_W'(CHANNELS - 1);
    localparam logic [SEL_W-1:0]   CHAN_ONE   = SEL_W'(1);

    logic [SEL_W-1:0]   chan_r;
    logic [DWELL_W-1:0] dwell_r;
    logic [SEL_W-1:0]   chan_nxt_s;
    logic [DWELL_W-1:0] dwell_nxt_s;
    logic               wrap_nxt_s;

    // Next scan position: clear, hold, or advance one dwell cycle.
    always_comb begin
        chan_nxt_s  = chan_r;
        dwell_nxt_s = dwell_r;
        wrap_nxt_s  = 1'b0;
        if (clear) begin
            chan_nxt_s  = {SEL_W{1'b0}};
            dwell_nxt_s = {DWELL_W{1'b0}};
            wrap_nxt_s  = 1'b0;
        end else if (hold) begin
            chan_nxt_s  = chan_r;
            dwell_nxt_s = dwell_r;
            wrap_nxt_s  = 1'b0;
        end else begin
            // ">=" keeps a corrupted counter from running past its range.
            if (dwell_r >= LAST_DWELL) begin
                dwell_nxt_s = {DWELL_W{1'b0}};
                if (chan_r >= LAST_CHAN) begin
                    chan_nxt_s = {SEL_W{1'b0}};
                    wrap_nxt_s = 1'b1;
                end else begin
                    chan_nxt_s = chan_r + CHAN_ONE;
                    wrap_nxt_s = 1'b0;
                end
            end else begin
                dwell_nxt_s = dwell_r + DWELL_ONE;
                chan_nxt_s  = chan_r;
                wrap_nxt_s  = 1'b0;
            end
        end
    end

    // Scan position registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            chan_r  <= {SEL_W{1'b0}};
            dwell_r <= {DWELL_W{1'b0}};
        end else begin
            chan_r  <= chan_nxt_s;
            dwell_r <= dwell_nxt_s;
        end
    end

    assign chan_next = chan_nxt_s;
    assign wrap_next = wrap_nxt_s;

endmodule

// File: rtl/mux_scan_sel.sv
// Registered N-channel, W-bit multiplexer with a manual select mode and an
// automatic scan mode that dwells DWELL cycles on every channel in turn.
// Outputs carry a valid flag, the driving channel and a scan wrap pulse.
module mux_scan_sel #(
    parameter int  WIDTH    = 4,
    parameter int  CHANNELS = 4,
    parameter int  DWELL    = 8,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic                      mode,
    input  logic                      en,
    output logic [WIDTH-1:0]          dout,
    output logic [SEL_W-1:0]          sel_out,
    output logic                      dout_valid,
    output logic                      scan_wrap
);
    import mux_scan_pkg::*;

    localparam logic [SEL_W:0] CHAN_COUNT = (SEL_W + 1)'(CHANNELS);

    state_t           state_r;
    state_t           state_nxt_s;
    last_active_t     last_active_r;
    last_active_t     last_active_nxt_s;

    logic             cnt_clear_s;
    logic             cnt_hold_s;
    logic [SEL_W-1:0] scan_chan_s;
    logic             scan_wrap_s;
    logic             scan_fresh_s;
    logic             manual_in_range_s;
    logic [WIDTH-1:0] manual_data_s;
    logic [WIDTH-1:0] scan_data_s;

    logic [WIDTH-1:0] dout_r;
    logic [SEL_W-1:0] sel_r;
    logic             valid_r;
    logic             wrap_r;
    logic [WIDTH-1:0] dout_nxt_s;
    logic [SEL_W-1:0] sel_nxt_s;
    logic             valid_nxt_s;
    logic             wrap_nxt_s;

    // Extract one channel from the flattened bus; indices past the last
    // channel yield zero.
    function automatic logic [WIDTH-1:0] pick_channel(
        input logic [CHANNELS*WIDTH-1:0] bus,
        input logic [SEL_W-1:0]          idx
    );
        logic [WIDTH-1:0] data;
        data = {WIDTH{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            data = (idx == SEL_W'(i)) ? bus[i*WIDTH +: WIDTH] : data;
        end
        return data;
    endfunction

    scan_counter #(
        .CHANNELS (CHANNELS),
        .DWELL    (DWELL),
        .SEL_W    (SEL_W)
    ) u_scan_counter (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (cnt_clear_s),
        .hold      (cnt_hold_s),
        .chan_next (scan_chan_s),
        .wrap_next (scan_wrap_s)
    );

    // Data-path lookups for both modes.
    always_comb begin
        manual_in_range_s = ({1'b0, sel_in} < CHAN_COUNT);
        manual_data_s     = pick_channel(din, sel_in);
        scan_data_s       = pick_channel(din, scan_chan_s);
    end

    // A scan restarts unless it was running, or paused out of a running scan.
    // Any unexpected state value also forces a clean restart.
    always_comb begin
        scan_fresh_s = !((state_r == ST_SCAN) ||
                         ((state_r == ST_IDLE) && (last_active_r == LAST_SCAN)));
    end

    // Next-state decode, counter control and next output values.
    always_comb begin
        state_nxt_s       = decode_state(en, mode);
        last_active_nxt_s = last_active_r;
        cnt_clear_s       = 1'b0;
        cnt_hold_s        = 1'b1;
        dout_nxt_s        = dout_r;
        sel_nxt_s         = sel_r;
        valid_nxt_s       = 1'b0;
        wrap_nxt_s        = 1'b0;
        case (state_nxt_s)
            ST_IDLE: begin
                // Outputs and scan position hold; data is flagged stale.
                cnt_clear_s = 1'b0;
                cnt_hold_s  = 1'b1;
                valid_nxt_s = 1'b0;
                wrap_nxt_s  = 1'b0;
            end
            ST_MANUAL: begin
                // Scan position is discarded; the next scan starts at channel 0.
                last_active_nxt_s = LAST_MANUAL;
                cnt_clear_s       = 1'b1;
                cnt_hold_s        = 1'b0;
                sel_nxt_s         = sel_in;
                wrap_nxt_s        = 1'b0;
                if (manual_in_range_s) begin
                    dout_nxt_s  = manual_data_s;
                    valid_nxt_s = 1'b1;
                end else begin
                    dout_nxt_s  = {WIDTH{1'b0}};
                    valid_nxt_s = 1'b0;
                end
            end
            ST_SCAN: begin
                last_active_nxt_s = LAST_SCAN;
                cnt_clear_s       = scan_fresh_s;
                cnt_hold_s        = 1'b0;
                dout_nxt_s        = scan_data_s;
                sel_nxt_s         = scan_chan_s;
                valid_nxt_s       = 1'b1;
                wrap_nxt_s        = scan_wrap_s;
            end
            default: begin
                cnt_clear_s = 1'b0;
                cnt_hold_s  = 1'b1;
                valid_nxt_s = 1'b0;
                wrap_nxt_s  = 1'b0;
            end
        endcase
    end

    // State and last-active-mode registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r       <= ST_IDLE;
            last_active_r <= LAST_MANUAL;
        end else begin
            state_r       <= state_nxt_s;
            last_active_r <= last_active_nxt_s;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dout_r  <= {WIDTH{1'b0}};
            sel_r   <= {SEL_W{1'b0}};
            valid_r <= 1'b0;
            wrap_r  <= 1'b0;
        end else begin
            dout_r  <= dout_nxt_s;
            sel_r   <= sel_nxt_s;
            valid_r <= valid_nxt_s;
            wrap_r  <= wrap_nxt_s;
        end
    end

    assign dout       = dout_r;
    assign sel_out    = sel_r;
    assign dout_valid = valid_r;
    assign scan_wrap  = wrap_r;

endmodule

// File: tb/tb_mux_scan_sel.sv
// Bench for mux_scan_sel: a 4-channel/dwell-3 instance and a 3-channel/dwell-1
// instance share control inputs. A driver applies stimulus on the falling edge
// and queues the reference model's prediction; a monitor pops and compares
// after every rising edge.
module tb_mux_scan_sel;

    typedef struct packed {
        logic [3:0] dout;
        logic [1:0] sel;
        logic       valid;
        logic       wrap;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] din;
    logic [1:0]  sel_in;
    logic        mode;
    logic        en;

    logic [3:0] dout_a, dout_b;
    logic [1:0] sel_a, sel_b;
    logic       valid_a, valid_b, wrap_a, wrap_b;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t q_a[$];
    exp_t q_b[$];

    // Reference model state per instance (0 = 4ch/dwell 3, 1 = 3ch/dwell 1).
    int          m_chans[2] = '{4, 3};
    int          m_dwell[2] = '{3, 1};
    int          m_prev[2];   // 0 idle, 1 manual, 2 scan on the previous edge
    int          m_last[2];   // 1 manual, 2 scan: last active mode
    int          m_t[2];      // scan cycles since the scan started
    logic [3:0]  m_dout[2];
    logic [1:0]  m_sel[2];

    always #5 clk = ~clk;

    mux_scan_sel #(.WIDTH(4), .CHANNELS(4), .DWELL(3)) dut_a (
        .clk        (clk),
        .resetn     (resetn),
        .din        (din),
        .sel_in     (sel_in),
        .mode       (mode),
        .en         (en),
        .dout       (dout_a),
        .sel_out    (sel_a),
        .dout_valid (valid_a),
        .scan_wrap  (wrap_a)
    );

    mux_scan_sel #(.WIDTH(4), .CHANNELS(3), .DWELL(1)) dut_b (
        .clk        (clk),
        .resetn     (resetn),
        .din        (din[11:0]),
        .sel_in     (sel_in),
        .mode       (mode),
        .en         (en),
        .dout       (dout_b),
        .sel_out    (sel_b),
        .dout_valid (valid_b),
        .scan_wrap  (wrap_b)
    );

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_prev[m] = 0;
            m_last[m] = 1;
            m_t[m]    = 0;
            m_dout[m] = 4'h0;
            m_sel[m]  = 2'd0;
        end
    endtask

    // Predict what instance m shows after the coming rising edge.
    task automatic model_step(input int m, output exp_t e);
        int ch;
        e = '0;
        if (!en) begin
            e.dout = m_dout[m]; e.sel = m_sel[m]; e.valid = 1'b0; e.wrap = 1'b0;
            m_prev[m] = 0;
        end else if (!mode) begin
            e.sel  = sel_in;
            e.wrap = 1'b0;
            if (int'(sel_in) < m_chans[m]) begin
                e.dout = din[int'(sel_in)*4 +: 4]; e.valid = 1'b1;
            end else begin
                e.dout = 4'h0; e.valid = 1'b0;
            end
            m_prev[m] = 1; m_last[m] = 1;
        end else begin
            if (m_prev[m] == 1 || (m_prev[m] == 0 && m_last[m] == 1)) m_t[m] = 0;
            else m_t[m] = m_t[m] + 1;
            ch = (m_t[m] / m_dwell[m]) % m_chans[m];
            e.dout  = din[ch*4 +: 4];
            e.sel   = 2'(ch);
            e.valid = 1'b1;
            e.wrap  = (m_t[m] > 0) && (m_t[m] % (m_dwell[m] * m_chans[m]) == 0);
            m_prev[m] = 2; m_last[m] = 2;
        end
        m_dout[m] = e.dout;
        m_sel[m]  = e.sel;
    endtask

    task automatic push_model();
        exp_t e;
        model_step(0, e); q_a.push_back(e);
        model_step(1, e); q_b.push_back(e);
    endtask

    task automatic cycle(input logic e_i, input logic m_i, input logic [1:0] s_i,
                         input logic [15:0] d_i);
        @(negedge clk);
        en = e_i; mode = m_i; sel_in = s_i; din = d_i;
        push_model();
    endtask

    task automatic check(input string nm, input logic [3:0] d, input logic [1:0] s,
                         input logic v, input logic w, input exp_t e);
        n_checks++;
        if ({d, s, v, w} !== {e.dout, e.sel, e.valid, e.wrap}) begin
            n_fail++;
            $display("FAIL %s @%0t: got dout=%h sel=%0d valid=%b wrap=%b, expected dout=%h sel=%0d valid=%b wrap=%b",
                     nm, $time, d, s, v, w, e.dout, e.sel, e.valid, e.wrap);
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        resetn = 1'b1;
        push_model();
    endtask

    // Assert reset between edges and check the outputs clear immediately.
    task automatic reset_mid_cycle();
        exp_t zero;
        zero = '0;
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check("async_reset_a", dout_a, sel_a, valid_a, wrap_a, zero);
        check("async_reset_b", dout_b, sel_b, valid_b, wrap_b, zero);
        model_reset();
        en = 1'b0;
        repeat (2) @(posedge clk);
        release_reset();
    endtask

    // Monitor: compare each instance against its queued prediction.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q_a.size() != 0) begin
            e = q_a.pop_front();
            check("out_a", dout_a, sel_a, valid_a, wrap_a, e);
        end
        if (q_b.size() != 0) begin
            e = q_b.pop_front();
            check("out_b", dout_b, sel_b, valid_b, wrap_b, e);
        end
    end

    initial begin
        logic r_en, r_mode;
        resetn = 1'b0; en = 1'b0; mode = 1'b0; sel_in = 2'd0; din = 16'h0000;
        model_reset();
        repeat (2) @(posedge clk);
        release_reset();

        // Manual select, then live data change on the selected channel.
        cycle(1'b1, 1'b0, 2'd2, 16'hDCBA);
        cycle(1'b1, 1'b0, 2'd2, 16'hD5BA);
        cycle(1'b1, 1'b0, 2'd2, 16'hD5BA);

        // Full scan lap from manual, including the wrap back to channel 0.
        for (int i = 0; i < 14; i++) cycle(1'b1, 1'b1, 2'(i), 16'hDCBA);

        // Pause two cycles into channel 1, then resume.
        cycle(1'b1, 1'b0, 2'd0, 16'hDCBA);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 2'd0, 16'hDCBA);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 2'd0, 16'hDCBA);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 2'd0, 16'hDCBA);

        // Out-of-range select (3-channel instance), then a valid one.
        cycle(1'b1, 1'b0, 2'd3, 16'hDCBA);
        cycle(1'b0, 1'b0, 2'd3, 16'hDCBA);
        cycle(1'b1, 1'b0, 2'd1, 16'hDCBA);

        // Scan to channel 1, jump to manual channel 3, restart the scan.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 2'd0, 16'hDCBA);
        cycle(1'b1, 1'b0, 2'd3, 16'hDCBA);
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 2'd0, 16'hDCBA);

        // Reset in the middle of a scan.
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 2'd0, 16'hDCBA);
        reset_mid_cycle();

        // Randomised traffic with occasional pauses and mode flips.
        r_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) reset_mid_cycle();
            r_en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 39) == 0) r_mode = ~r_mode;
            cycle(r_en, r_mode, 2'($urandom_range(0, 3)), 16'($urandom()));
        end

        cycle(1'b0, 1'b0, 2'd0, 16'h0000);
        @(posedge clk);
        #2;
        n_checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d/%0d entries left, expected 0/0",
                     q_a.size(), q_b.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_scan_sel.md
Name: mux_scan_sel

Overview:
Parametrised registered N-channel, W-bit multiplexer, the successor to the 1-bit 4:1 combinational mux. It has two modes. Manual mode routes the channel on sel_in. Scan mode steps through all channels automatically, holding each one for a programmable dwell time. It sits between input sources and a display or capture stage and gives a registered output with a valid flag and a channel tag.

Parameters:
WIDTH, 4, bit width of each channel
CHANNELS, 4, number of input channels (2..16)
DWELL, 8, cycles spent on each channel in scan mode (>=1)
SEL_W, $clog2(CHANNELS), derived localparam, select width

Ports:
clk  input  1  rising-edge clock
resetn  input  1  asynchronous active-low reset
din  input  CHANNELS*WIDTH  flattened channel data; channel i = din[i*WIDTH +: WIDTH]
sel_in  input  SEL_W  channel select in manual mode
mode  input  1  0 = manual, 1 = scan
en  input  1  1 = active, 0 = pause/hold
dout  output  WIDTH  registered selected data
sel_out  output  SEL_W  channel currently driving dout
dout_valid  output  1  dout holds a valid in-range channel
scan_wrap  output  1  single-cycle pulse when scan wraps from last channel to channel 0

Behaviour:
- Reset (resetn=0, asynchronous, effective immediately, also mid-operation):
  - dout=0, sel_out=0, dout_valid=0, scan_wrap=0.
  - Channel counter=0, dwell counter=0, state=IDLE, last_active=MANUAL.
- States:
  - IDLE: en=0.
  - MANUAL: en=1, mode=0.
  - SCAN: en=1, mode=1.
  - The next state is decoded every cycle from en/mode.
- IDLE:
  - dout and sel_out hold their values; dout_valid=0; scan_wrap=0.
  - Channel and dwell counters freeze.
- MANUAL:
  - On each edge: dout<=din[sel_in], sel_out<=sel_in, dout_valid<=1.
  - Latency is 1 cycle from sel_in or din to dout.
  - Out-of-range sel_in (>=CHANNELS, possible only when CHANNELS is not a power of 2): dout<=0, sel_out<=sel_in, dout_valid<=0.
- SCAN:
  - Entry from MANUAL, or from IDLE with last_active=MANUAL: channel<=0, dwell<=0.
  - Entry from IDLE with last_active=SCAN: resume from the frozen channel and dwell count.
  - Each cycle dout<=din[channel] tracks live data; dout_valid<=1; sel_out<=channel.
  - Dwell counts 0..DWELL-1. At DWELL-1 the channel advances and dwell resets to 0.
  - Each channel therefore occupies exactly DWELL consecutive dout cycles. With DWELL=1 the channel changes every cycle.
  - Wrap: advancing from CHANNELS-1 to 0 asserts scan_wrap for exactly the one cycle in which sel_out first shows 0.
- Mode change SCAN->MANUAL takes effect at the next edge: dout=din[sel_in] and the scan counters are discarded.
- en drop mid-dwell: pause with no lost or extra dwell cycles on resume.
- Simultaneous en=1 with a mode change on the same edge: mode wins as decoded. No intermediate state.
- All arithmetic is unsigned; counters are sized to SEL_W and $clog2(DWELL)+1 with no overflow.

Decomposition:
- Shared package mux_scan_pkg holds:
  - State encoding (IDLE, MANUAL, SCAN).
  - MODE_MANUAL/MODE_SCAN constants.
  - The last_active encoding.
- One sub-module, scan_counter, holds the dwell counter and channel counter with wrap pulse, clear, and hold inputs. The top level holds the FSM, data selection, and output registers.

Test Plan (WIDTH=4, CHANNELS=4, DWELL=3, din ch0..ch3 = A,B,C,D unless noted):
1. Assert resetn=0 mid-scan between edges -> dout=0, sel_out=0, dout_valid=0, scan_wrap=0 immediately, before the next edge. Release -> IDLE.
2. Manual:
   - en=1, mode=0, sel_in=2 at edge k -> dout=C, sel_out=2, dout_valid=1 at edge k+1.
   - Then ch2 := 5 -> dout=5 one edge later.
3. Scan: en=1, mode=1 from MANUAL -> sel_out sequence 0,0,0,1,1,1,2,2,2,3,3,3,0 with dout A,A,A,B,...,D,A. scan_wrap=1 only on the 13th cycle.
4. Pause: en=0 after 2 cycles on ch1, held for 5 cycles -> dout=B held, dout_valid=0. en=1 -> exactly 1 more cycle on ch1, then ch2.
5. CHANNELS=3 instance, manual, sel_in=3 -> dout=0, sel_out=3, dout_valid=0. sel_in=1 -> dout=B, dout_valid=1.
6. Scan on ch1, switch mode=0 with sel_in=3 -> next edge dout=D. mode=1 again -> restart at ch0 with dwell 3; no scan_wrap during the switch.
